// File: rtl/servstolic_pkg.sv
// Shared layout of a queued toggle event and the width of the drop counter.
// Entry packing, LSB first: timestamp, level, core index.
package servstolic_pkg;

    localparam int DROP_W = 8;
    localparam int LVL_W  = 1;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic int ev_width(input int core_w, input int time_w);
        return core_w + LVL_W + time_w;
    endfunction

    function automatic int ev_lvl_pos(input int time_w);
        return time_w;
    endfunction

    function automatic int ev_core_lsb(input int time_w);
        return time_w + LVL_W;
    endfunction

endpackage

// File: rtl/servstolic_evfifo.sv
// First-word-fall-through event FIFO; head visible the cycle after the write.
// Accepts a push when not full, or when full and popped in the same cycle.
module servstolic_evfifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdat,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdat,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_rdat  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge wb_clk) begin
        if (w_push && !wb_rst) begin
            r_mem[r_wr_ptr] <= i_wdat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/servstolic_qmon.sv
// Watches the servant-grid GPIOs and queues one timestamped event per toggle, round-robin.
// Change in cycle n reaches evt_valid in n+2; a full FIFO stalls grants and re-toggles become drops.
module servstolic_qmon
    import servstolic_pkg::*;
#(
    parameter int NROW  = 4,
    parameter int NCOL  = 4,
    parameter int TSW   = 16,
    parameter int DEPTH = 8
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst,
    input  logic [NROW*NCOL-1:0]          q,
    input  logic                          evt_ready,
    output logic                          evt_valid,
    output logic [$clog2(NROW*NCOL)-1:0]  evt_core,
    output logic                          evt_level,
    output logic [TSW-1:0]                evt_time,
    output logic                          overflow,
    output logic [DROP_W-1:0]             drop_cnt
);

    localparam int NCORE = NROW * NCOL;
    localparam int CW    = $clog2(NCORE);
    localparam int EW    = ev_width(CW, TSW);
    localparam int SW    = DROP_W + CW + 1;

    logic [NCORE-1:0]  r_q_d;
    logic [NCORE-1:0]  r_pend;
    logic [NCORE-1:0]  r_lvl;
    logic [TSW-1:0]    r_time;
    logic [CW-1:0]     r_last;
    logic              r_ovf;
    logic [DROP_W-1:0] r_drop;

    logic [NCORE-1:0]  w_change;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_can_wr;
    logic              w_gnt_vld;
    logic [CW-1:0]     w_gnt_idx;
    logic [NCORE-1:0]  w_gnt_oh;
    logic [NCORE-1:0]  w_drop_vec;
    logic [CW:0]       w_drop_n;
    logic [SW-1:0]     w_drop_sum;
    logic [DROP_W-1:0] w_drop_nxt;
    logic [EW-1:0]     w_wdat;
    logic [EW-1:0]     w_rdat;

    assign w_change  = q ^ r_q_d;
    assign evt_valid = ~w_empty & ~wb_rst;
    assign w_pop     = evt_valid & evt_ready;
    assign w_can_wr  = ~w_full | w_pop;

    // Scan downwards so the candidate closest after r_last is written last and wins.
    always_comb begin
        logic [CW:0] w_idx;
        w_idx     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = NCORE; k >= 1; k--) begin
            w_idx = {1'b0, r_last} + (CW+1)'(k);
            if (w_idx >= (CW+1)'(NCORE)) begin
                w_idx = w_idx - (CW+1)'(NCORE);
            end
            if (r_pend[w_idx[CW-1:0]] && w_can_wr) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx[CW-1:0];
            end
        end
    end

    assign w_gnt_oh   = w_gnt_vld ? (NCORE'(1) << w_gnt_idx) : '0;
    assign w_drop_vec = w_change & r_pend & ~w_gnt_oh;

    always_comb begin
        w_drop_n = '0;
        for (int i = 0; i < NCORE; i++) begin
            w_drop_n = w_drop_n + (CW+1)'(w_drop_vec[i]);
        end
    end

    assign w_drop_sum = SW'(r_drop) + SW'(w_drop_n);
    assign w_drop_nxt = (w_drop_sum > SW'(DROP_MAX)) ? DROP_MAX : w_drop_sum[DROP_W-1:0];

    assign w_wdat = {w_gnt_idx, r_lvl[w_gnt_idx], r_time};

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_q_d  <= '0;
            r_pend <= '0;
            r_lvl  <= '0;
            r_time <= '0;
            r_last <= CW'(NCORE - 1);
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else begin
            r_q_d  <= q;
            // A fresh change on the granted core re-arms it rather than counting as a drop.
            r_pend <= (r_pend & ~w_gnt_oh) | w_change;
            r_lvl  <= (r_lvl & ~w_change) | (q & w_change);
            r_time <= r_time + TSW'(1);
            if (w_gnt_vld) begin
                r_last <= w_gnt_idx;
            end
            if (|w_drop_vec) begin
                r_ovf <= 1'b1;
            end
            r_drop <= w_drop_nxt;
        end
    end

    servstolic_evfifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_evfifo (
        .wb_clk  (wb_clk),
        .wb_rst  (wb_rst),
        .i_push  (w_gnt_vld),
        .i_wdat  (w_wdat),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_rdat  (w_rdat),
        .o_empty (w_empty)
    );

    assign evt_time  = w_rdat[TSW-1:0];
    assign evt_level = w_rdat[ev_lvl_pos(TSW)];
    assign evt_core  = w_rdat[ev_core_lsb(TSW) +: CW];
    assign overflow  = r_ovf;
    assign drop_cnt  = r_drop;

endmodule

// File: doc/servstolic_qmon.md
SERVSTOLIC_QMON -- requirements
Module: servstolic_qmon

Interface
REQ-001 Parameter NROW, default 4, rows of the servant grid.
REQ-002 Parameter NCOL, default 4, columns of the servant grid; NCORE = NROW*NCOL.
REQ-003 Parameter TSW, default 16, timestamp width in bits.
REQ-004 Parameter DEPTH, default 8, event FIFO depth; power of two, >= 2.
REQ-005 wb_clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-006 wb_rst  input  1  reset, synchronous and active-high.
REQ-007 q  input  NCORE  grid GPIO outputs; bit index = NCOL*row + col; synchronous to wb_clk.
REQ-008 evt_ready  input  1  consumer accepts the head event.
REQ-009 evt_valid  output  1  head event present.
REQ-010 evt_core  output  clog2(NCORE)  index of the core that toggled.
REQ-011 evt_level  output  1  new level of that core's q.
REQ-012 evt_time  output  TSW  timestamp of the grant cycle.
REQ-013 overflow  output  1  sticky; at least one toggle was lost.
REQ-014 drop_cnt  output  8  saturating count of lost toggles.

Function
REQ-015 q_d SHALL register q every cycle; change = q XOR q_d.
REQ-016 A change on bit i SHALL set pending[i] at the end of the cycle; lvl[i] SHALL capture q[i].
REQ-017 A free-running TSW-bit counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-018 Each cycle, when the FIFO can accept a write, one pending core SHALL be granted round-robin, starting from last_grant+1 modulo NCORE.
REQ-019 The grant SHALL write {core, lvl[core], counter} to the FIFO and clear pending[core].
REQ-020 If the granted core has a new change in the same cycle, pending SHALL stay set and lvl SHALL update; this is not a drop.
REQ-021 A change on a core whose pending bit is set and is not granted that cycle SHALL be a drop:
- overflow SHALL be set.
- drop_cnt SHALL increment, saturating at 255.
- lvl SHALL take the new value.
REQ-022 Several drops in one cycle SHALL add their count to drop_cnt, saturating at 255.
REQ-023 The FIFO SHALL be first-word-fall-through: evt_valid = not empty, and the evt_* outputs show the head entry.
REQ-024 A pop SHALL occur when evt_valid and evt_ready are both high.
REQ-025 The FIFO SHALL accept a write when count < DEPTH, or when it is full and a pop occurs in the same cycle.
REQ-026 The evt_* outputs SHALL stay stable while evt_valid is high and evt_ready is low.
REQ-027 Latency: a change present in cycle n with an empty FIFO and no competition SHALL give evt_valid high in cycle n+2.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 With the FIFO full and no pop, no grant SHALL occur and pending bits SHALL hold.

Reset
REQ-030 While wb_rst is high, the following SHALL be cleared to 0 at the next clock edge: q_d, pending, lvl, counter, FIFO pointers and count, overflow, drop_cnt.
REQ-031 While wb_rst is high, last_grant SHALL be set to NCORE-1, so core 0 has first priority.
REQ-032 While wb_rst is high, evt_valid SHALL be 0; an assertion mid-operation SHALL discard all queued and pending events.
REQ-033 The cycle after reset deasserts, q bits that are 1 SHALL register as changes, because q_d resets to 0.

Structure
REQ-034 Package servstolic_pkg SHALL hold the event entry layout (core, level, time field widths) and the drop_cnt width constant.
REQ-035 The FIFO SHALL be the sub-module servstolic_evfifo (parameters width and DEPTH; push/full, pop/empty ports); arbitration and edge detection stay in the top level.

Verification
REQ-036 Reset, then drive q=0x0001 at cycle 5 with evt_ready=1 -> at cycle 7: evt_valid=1, evt_core=0, evt_level=1, evt_time=6.
REQ-037 Toggle q bits 3, 7 and 12 together with evt_ready=1 -> events appear for cores 3, 7, 12 on consecutive cycles; overflow stays 0.
REQ-038 Hold evt_ready=0 and toggle 9 distinct cores with DEPTH=8 -> the FIFO holds 8 events and the 9th stays pending; raise evt_ready -> the 9th event appears; overflow stays 0.
REQ-039 With evt_ready=0 and the FIFO full, toggle core 2 three times -> drop_cnt=2, overflow=1; the later event for core 2 carries the final level.
REQ-040 Assert wb_rst for 1 cycle while 4 events are queued -> the cycle after the reset edge, evt_valid=0 and drop_cnt=0, and no stale events appear afterwards.
